// File: rtl/riscv_pkg.sv
// Shared definitions for the memory port arbiter: widths, port indices, response register.
package riscv_pkg;

  localparam int unsigned MEM_AW_DEFAULT = 8;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } resp_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory signals of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned MEM_AW = riscv_pkg::MEM_AW_DEFAULT
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Requesters and the memory model sit on the master side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_rr_ptr.sv
// Grant selection between fetch and data ports; owns the last_grant pointer.
// ARB_DATA_PRIORITY_EN selects fixed data-port priority instead of round-robin.
module arb_rr_ptr
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_if_i,
  input  logic req_d_i,
  output logic gnt_if_o,
  output logic gnt_d_o
);

  logic tie_to_d;

`ifdef ARB_DATA_PRIORITY_EN
  assign tie_to_d = 1'b1;
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_if_o) begin
      last_grant_d = PORT_IF;
    end else if (gnt_d_o) begin
      last_grant_d = PORT_D;
    end
  end

  // Reset to the data port so the first tie goes to fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= PORT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign tie_to_d = (last_grant_q == PORT_IF);
`endif

  always_comb begin
    gnt_if_o = req_if_i & ~(req_d_i & tie_to_d);
    gnt_d_o  = req_d_i & ~(req_if_i & ~tie_to_d);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-cycle-latency shared memory.
// Optional build macro: ARB_DATA_PRIORITY_EN (fixed data priority, see arb_rr_ptr).
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  mem_port_arbiter_if.slave bus
);

  logic  req_if, req_d;
  logic  gnt_if, gnt_d;
  resp_t resp_q, resp_d;

  // Requests seen during reset are dropped.
  assign req_if = bus.if_req & ~reset;
  assign req_d  = bus.d_req & ~reset;

  arb_rr_ptr u_arb_rr_ptr (
    .clk      (clk),
    .reset    (reset),
    .req_if_i (req_if),
    .req_d_i  (req_d),
    .gnt_if_o (gnt_if),
    .gnt_d_o  (gnt_d)
  );

  always_comb begin
    bus.if_gnt    = gnt_if;
    bus.d_gnt     = gnt_d;
    bus.mem_en    = gnt_if | gnt_d;
    bus.mem_we    = gnt_d & bus.d_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_if) begin
      bus.mem_addr = bus.if_addr[MEM_AW+1:2];
    end else if (gnt_d) begin
      bus.mem_addr  = bus.d_addr[MEM_AW+1:2];
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    resp_d.valid = gnt_if | (gnt_d & ~bus.d_we);
    resp_d.port  = gnt_d ? PORT_D : PORT_IF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  // A response landing on a reset cycle is discarded.
  always_comb begin
    bus.if_rvalid = resp_q.valid & ~reset & (resp_q.port == PORT_IF);
    bus.d_rvalid  = resp_q.valid & ~reset & (resp_q.port == PORT_D);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle reference model plus directed literals.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.MEM_AW(AW)) bus ();

  mem_port_arbiter #(.MEM_AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Environment memory: one-cycle read latency, driven by the DUT's memory outputs.
  logic [31:0] memarr    [256];
  logic [31:0] model_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      memarr[i]    = init_word(i);
      model_mem[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) memarr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= memarr[bus.mem_addr];
    end
  end

  // Reference model: last winner, one pending read response, memory image.
  logic        m_last_d;
  logic        m_pv, m_pp;
  logic [31:0] m_pd;
  int          if_wait, d_wait;

  always @(negedge clk) begin
    logic        e_if, e_d, e_we, e_irv, e_drv;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    if (reset) begin
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_d_gnt", bus.d_gnt, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_d_rvalid", bus.d_rvalid, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      m_last_d = 1'b1;
      m_pv     = 1'b0;
      if_wait  = 0;
      d_wait   = 0;
    end else begin
`ifdef ARB_DATA_PRIORITY_EN
      e_d  = bus.d_req;
      e_if = bus.if_req && !bus.d_req;
`else
      if (bus.if_req && bus.d_req) begin
        e_if = m_last_d;
        e_d  = !m_last_d;
      end else begin
        e_if = bus.if_req;
        e_d  = bus.d_req;
      end
`endif
      e_we   = e_d && bus.d_we;
      e_addr = e_if ? bus.if_addr[9:2] : (e_d ? bus.d_addr[9:2] : 8'h00);
      e_wd   = e_d ? bus.d_wdata : 32'h0;
      e_irv  = m_pv && (m_pp == 1'b0);
      e_drv  = m_pv && (m_pp == 1'b1);

      chk("if_gnt", bus.if_gnt, e_if);
      chk("d_gnt", bus.d_gnt, e_d);
      chk("mem_en", bus.mem_en, e_if || e_d);
      chk("mem_we", bus.mem_we, e_we);
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("mem_wdata", bus.mem_wdata, e_wd);
      chk("if_rvalid", bus.if_rvalid, e_irv);
      chk("d_rvalid", bus.d_rvalid, e_drv);
      chk("if_rdata", bus.if_rdata, e_irv ? m_pd : 32'h0);
      chk("d_rdata", bus.d_rdata, e_drv ? m_pd : 32'h0);

      if_wait = (bus.if_req && !bus.if_gnt) ? if_wait + 1 : 0;
      d_wait  = (bus.d_req && !bus.d_gnt) ? d_wait + 1 : 0;
      chk("d_starve", 32'(d_wait > 1), 0);
`ifndef ARB_DATA_PRIORITY_EN
      chk("if_starve", 32'(if_wait > 1), 0);
`endif

      if (e_if || e_d) m_last_d = e_d;
      m_pv = e_if || (e_d && !bus.d_we);
      m_pp = e_d;
      m_pd = model_mem[e_addr];
      if (e_we) model_mem[e_addr] = bus.d_wdata;
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic rst);
    @(posedge clk);
    #1;
    reset       = rst;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    @(negedge clk);
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    reset       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("lit_rst_ignores_req", bus.if_gnt, 0);

    // Lone fetch read.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lit_if_gnt", bus.if_gnt, 1);
    chk("lit_if_mem_addr", 32'(bus.mem_addr), 0);
    chk("lit_if_mem_we", bus.mem_we, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lit_if_rvalid", bus.if_rvalid, 1);
    chk("lit_if_rdata", bus.if_rdata, 32'hA5A5_0000);

    // Store then load from an unaligned address in the same word.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    chk("lit_st_gnt", bus.d_gnt, 1);
    chk("lit_st_we", bus.mem_we, 1);
    chk("lit_st_addr", 32'(bus.mem_addr), 4);
    chk("lit_st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("lit_st_no_rvalid", bus.d_rvalid, 0);
    chk("lit_ld_addr", 32'(bus.mem_addr), 4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lit_ld_rvalid", bus.d_rvalid, 1);
    chk("lit_ld_rdata", bus.d_rdata, 32'hDEAD_BEEF);

    // Fresh reset, then both ports requesting continuously.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
`ifdef ARB_DATA_PRIORITY_EN
      chk("lit_tie_if_gnt", bus.if_gnt, 0);
      chk("lit_tie_d_gnt", bus.d_gnt, 1);
      if (k > 0) chk("lit_tie_d_rdata", bus.d_rdata, 32'hA5A5_000C);
`else
      chk("lit_tie_if_gnt", bus.if_gnt, 32'((k % 2) == 0));
      chk("lit_tie_d_gnt", bus.d_gnt, 32'((k % 2) == 1));
      if (k > 0) begin
        chk("lit_tie_if_rvalid", bus.if_rvalid, 32'((k % 2) == 1));
        chk("lit_tie_d_rvalid", bus.d_rvalid, 32'((k % 2) == 0));
      end
`endif
    end

    // Read grant followed by reset: response dropped, first tie afterwards goes to fetch.
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("lit_pre_rst_gnt", bus.if_gnt, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("lit_rst_drop_rvalid", bus.if_rvalid, 0);
    drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0);
`ifdef ARB_DATA_PRIORITY_EN
    chk("lit_post_rst_tie", bus.d_gnt, 1);
`else
    chk("lit_post_rst_tie", bus.if_gnt, 1);
`endif

    // Mixed traffic, checked by the model only.
    tbl[0] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h84, 32'h1234_5678};
    tbl[1] = '{1'b1, 32'h84, 1'b0, 1'b0, 32'h0,  32'h0};
    tbl[2] = '{1'b1, 32'h88, 1'b1, 1'b1, 32'h8C, 32'hCAFE_F00D};
    tbl[3] = '{1'b1, 32'h8C, 1'b1, 1'b0, 32'h3FC, 32'h0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h8E, 32'h0};
    tbl[5] = '{1'b1, 32'h3FF, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{1'b1, 32'h8C, 1'b1, 1'b1, 32'h90, 32'h5555_AAAA};
    tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0};
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].ir, tbl[v].ia, tbl[v].dr, tbl[v].dw, tbl[v].da, tbl[v].dwd, 1'b0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_AW, default 8, word-address width of the shared memory (256 words).
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch port (port 0) read request.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  fetch read data valid.
REQ-008 if_rdata  output  32  fetch read data.
REQ-009 d_req  input  1  data port (port 1) request.
REQ-010 d_we  input  1  data port write enable (1 = store, 0 = load).
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_gnt, d_rvalid  output  1 each  data grant and load-data valid.
REQ-014 d_rdata  output  32  load data.
REQ-015 mem_en, mem_we  output  1 each  memory access strobe and write strobe.
REQ-016 mem_addr  output  MEM_AW  word address = granted addr[MEM_AW+1:2]; addr[1:0] ignored.
REQ-017 mem_wdata  output  32  store data of the granted port.
REQ-018 mem_rdata  input  32  memory read data, valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-019 At most one grant per cycle; grant combinational from current requests and state; if_gnt and d_gnt never both 1.
REQ-020 mem_en = if_gnt | d_gnt; mem_we = d_gnt & d_we; mem_addr/mem_wdata driven from the granted port; all memory outputs 0 with no grant.
REQ-021 Requester holds req, addr, we, wdata stable until its gnt; a request is consumed on the grant cycle.
REQ-022 Round-robin: 1-bit last_grant register; both requesting -> grant port opposite last_grant; updated on every grant.
REQ-023 Single requester granted in the same cycle regardless of last_grant.
REQ-024 Read response: 2-bit resp register {valid, port} loaded on each read grant; next cycle asserts if_rvalid or d_rvalid (one only) with rdata = mem_rdata.
REQ-025 Writes produce no rvalid; rdata outputs hold 0 when the matching rvalid is 0.
REQ-026 Back-to-back grants every cycle permitted; a response and a new grant may coincide; sustained throughput one access per cycle.
REQ-027 Starvation bound: a continuously requesting port is granted within 2 cycles.

Reset
REQ-028 During reset: all grants, rvalids, mem_en, mem_we 0; rdata, mem_addr, mem_wdata 0; last_grant = 1 (fetch wins first tie); resp cleared.
REQ-029 Requests asserted while reset is high are ignored; an in-flight read response is discarded if reset is high on its response cycle.

Configuration
REQ-030 Macro ARB_DATA_PRIORITY_EN defined: fixed priority, data port always wins ties, last_grant unused (REQ-027 then applies to data port only).
REQ-031 Macro ARB_DATA_PRIORITY_EN undefined: round-robin per REQ-022.

Structure
REQ-032 Shared package riscv_pkg holds MEM_AW default, port index constants PORT_IF=0/PORT_D=1, and resp-register typedef.
REQ-033 One sub-module arb_rr_ptr: last_grant register plus tie-break logic; the remainder stays in mem_port_arbiter.

Verification
REQ-034 Reset, then if_req=1 if_addr=0x0 alone -> if_gnt=1, mem_addr=0, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-035 Both requesting continuously after reset -> grants alternate IF, D, IF, D; rvalids follow each by one cycle on the matching port.
REQ-036 d_req=1 d_we=1 d_addr=0x10 d_wdata=0xDEADBEEF -> d_gnt=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF; next cycle d_rvalid=0.
REQ-037 d_addr=0x13 load -> mem_addr=4 (low bits dropped).
REQ-038 Reset asserted on the cycle after a read grant -> no rvalid; first tie after reset granted to IF.
REQ-039 With ARB_DATA_PRIORITY_EN defined, both requesting 4 cycles -> d_gnt=1 all 4 cycles, if_gnt=0.
